// File: rtl/ppu_op_dispatch.sv
// Issue stage in front of the PPU op sequencer: queues requests, runs one op at a time
// against the core under a watchdog, and returns each result over a valid/ready port.
module ppu_op_dispatch #(
   parameter int unsigned OP_SIZE = 3,
   parameter int unsigned N       = 16,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [OP_SIZE-1:0] in_op_i,
   input  logic [N-1:0]       in_a_i,
   input  logic [N-1:0]       in_b_i,
   output logic               core_en_o,
   output logic [OP_SIZE-1:0] core_op_o,
   output logic [N-1:0]       core_a_o,
   output logic [N-1:0]       core_b_o,
   input  logic               core_valid_i,
   input  logic [N-1:0]       core_result_i,
   output logic               res_valid_o,
   input  logic               res_ready_i,
   output logic [N-1:0]       res_data_o,
   output logic [OP_SIZE-1:0] res_op_o,
   output logic               err_o,
   output logic               busy_o
);

   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned WdogW = $clog2(TIMEOUT);

   localparam logic [CntW-1:0]    CntFull    = CntW'(DEPTH);
   localparam logic [WdogW-1:0]   WdogLast   = WdogW'(TIMEOUT - 1);
   localparam logic [OP_SIZE-1:0] FirstBadOp = OP_SIZE'(4);

   typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

   // Request FIFO
   logic [OP_SIZE-1:0] op_mem_q [DEPTH];
   logic [N-1:0]       a_mem_q  [DEPTH];
   logic [N-1:0]       b_mem_q  [DEPTH];
   logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]    count_q, count_d;
   logic               push, pop, fifo_empty;
   logic [OP_SIZE-1:0] head_op;
   logic [N-1:0]       head_a, head_b;

   // Issue FSM and output registers
   state_e             state_q, state_d;
   logic [WdogW-1:0]   wdog_q, wdog_d;
   logic               core_en_q, core_en_d;
   logic [OP_SIZE-1:0] core_op_q, core_op_d;
   logic [N-1:0]       core_a_q, core_a_d;
   logic [N-1:0]       core_b_q, core_b_d;
   logic               res_valid_q, res_valid_d;
   logic [N-1:0]       res_data_q, res_data_d;
   logic [OP_SIZE-1:0] res_op_q, res_op_d;
   logic               err_q, err_d;

   assign fifo_empty = (count_q == '0);
   // Held low through reset so nothing is accepted while the queue is being cleared.
   assign in_ready_o = rst & (count_q != CntFull);
   assign push       = in_valid_i & in_ready_o;

   assign head_op = op_mem_q[rd_ptr_q];
   assign head_a  = a_mem_q[rd_ptr_q];
   assign head_b  = b_mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         op_mem_q[wr_ptr_q] <= in_op_i;
         a_mem_q[wr_ptr_q]  <= in_a_i;
         b_mem_q[wr_ptr_q]  <= in_b_i;
      end
   end

   always_comb begin
      state_d     = state_q;
      wdog_d      = wdog_q;
      core_en_d   = core_en_q;
      core_op_d   = core_op_q;
      core_a_d    = core_a_q;
      core_b_d    = core_b_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_op_d    = res_op_q;
      err_d       = 1'b0;
      pop         = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               // Unsupported opcodes are consumed and reported, one per cycle.
               if (head_op >= FirstBadOp) begin
                  err_d = 1'b1;
               end else begin
                  core_op_d = head_op;
                  core_a_d  = head_a;
                  core_b_d  = head_b;
                  core_en_d = 1'b1;
                  wdog_d    = '0;
                  state_d   = StWait;
               end
            end
         end
         StWait: begin
            wdog_d = wdog_q + WdogW'(1);
            // A result arriving on the last watchdog cycle still wins.
            if (core_valid_i) begin
               res_data_d  = core_result_i;
               res_op_d    = core_op_q;
               res_valid_d = 1'b1;
               core_en_d   = 1'b0;
               state_d     = StHold;
            end else if (wdog_q == WdogLast) begin
               core_en_d = 1'b0;
               err_d     = 1'b1;
               state_d   = StIdle;
            end
         end
         StHold: begin
            if (res_ready_i) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= StIdle;
         wdog_q      <= '0;
         core_en_q   <= 1'b0;
         core_op_q   <= '0;
         core_a_q    <= '0;
         core_b_q    <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_op_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         wdog_q      <= wdog_d;
         core_en_q   <= core_en_d;
         core_op_q   <= core_op_d;
         core_a_q    <= core_a_d;
         core_b_q    <= core_b_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_op_q    <= res_op_d;
         err_q       <= err_d;
      end
   end

   assign core_en_o   = core_en_q;
   assign core_op_o   = core_op_q;
   assign core_a_o    = core_a_q;
   assign core_b_o    = core_b_q;
   assign res_valid_o = res_valid_q;
   assign res_data_o  = res_data_q;
   assign res_op_o    = res_op_q;
   assign err_o       = err_q;
   assign busy_o      = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_ppu_op_dispatch.sv
// Bench for ppu_op_dispatch: stand-in PPU core, queue-based reference model compared every
// cycle, directed scenarios with hand-derived expectations, then randomized traffic.
module tb_ppu_op_dispatch;

   localparam int unsigned OP_SIZE = 3;
   localparam int unsigned N       = 16;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 15;

   logic               clk;
   logic               rst;
   logic               in_valid_i;
   logic               in_ready_o;
   logic [OP_SIZE-1:0] in_op_i;
   logic [N-1:0]       in_a_i;
   logic [N-1:0]       in_b_i;
   logic               core_en_o;
   logic [OP_SIZE-1:0] core_op_o;
   logic [N-1:0]       core_a_o;
   logic [N-1:0]       core_b_o;
   logic               core_valid_i;
   logic [N-1:0]       core_result_i;
   logic               res_valid_o;
   logic               res_ready_i;
   logic [N-1:0]       res_data_o;
   logic [OP_SIZE-1:0] res_op_o;
   logic               err_o;
   logic               busy_o;

   ppu_op_dispatch #(
      .OP_SIZE (OP_SIZE),
      .N       (N),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .in_op_i       (in_op_i),
      .in_a_i        (in_a_i),
      .in_b_i        (in_b_i),
      .core_en_o     (core_en_o),
      .core_op_o     (core_op_o),
      .core_a_o      (core_a_o),
      .core_b_o      (core_b_o),
      .core_valid_i  (core_valid_i),
      .core_result_i (core_result_i),
      .res_valid_o   (res_valid_o),
      .res_ready_i   (res_ready_i),
      .res_data_o    (res_data_o),
      .res_op_o      (res_op_o),
      .err_o         (err_o),
      .busy_o        (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Stand-in core: result depends on all operands; ADD 0x4000,0x4000 gives 0x5000.
   function automatic logic [15:0] core_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
      return a + (b >> 2) + 16'(op);
   endfunction

   // ---------------- Reference model (queue + phase, updated per edge) ----------------
   typedef struct packed {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
   } req_t;

   req_t        mq[$];
   req_t        m_head, m_new;
   bit          m_live = 0, m_in_rst = 0, m_push;
   int          m_phase = 0, m_wcnt = 0;
   logic        m_en, m_rv, m_err;
   logic [2:0]  m_op, m_rop;
   logic [15:0] m_a, m_b, m_rdata;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst) begin
            mq.delete();
            m_phase = 0; m_wcnt = 0; m_en = 0; m_rv = 0; m_err = 0;
            m_op = 0; m_a = 0; m_b = 0; m_rop = 0; m_rdata = 0;
            m_live = 1; m_in_rst = 1;
         end else begin
            m_in_rst = 0;
            m_push = in_valid_i && (mq.size() != DEPTH);
            m_err = 0;
            if (m_phase == 0) begin
               if (mq.size() > 0) begin
                  m_head = mq.pop_front();
                  if (m_head.op >= 4) m_err = 1;
                  else begin
                     m_en = 1; m_op = m_head.op; m_a = m_head.a; m_b = m_head.b;
                     m_wcnt = 0; m_phase = 1;
                  end
               end
            end else if (m_phase == 1) begin
               if (core_valid_i) begin
                  m_rdata = core_result_i; m_rop = m_op; m_rv = 1; m_en = 0; m_phase = 2;
               end else if (m_wcnt == TIMEOUT - 1) begin
                  m_en = 0; m_err = 1; m_phase = 0;
               end else m_wcnt++;
            end else begin
               if (res_ready_i) begin
                  m_rv = 0; m_phase = 0;
               end
            end
            if (m_push) begin
               m_new.op = in_op_i; m_new.a = in_a_i; m_new.b = in_b_i;
               mq.push_back(m_new);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_live) begin
            check("in_ready", in_ready_o, rst && (mq.size() != DEPTH));
            check("core_en", core_en_o, m_en);
            check("res_valid", res_valid_o, m_rv);
            check("err", err_o, m_err);
            check("busy", busy_o, (m_phase != 0) || (mq.size() != 0));
            if (m_en || m_in_rst) begin
               check("core_op", core_op_o, m_op);
               check("core_a", core_a_o, m_a);
               check("core_b", core_b_o, m_b);
            end
            if (m_rv || m_in_rst) begin
               check("res_data", res_data_o, m_rdata);
               check("res_op", res_op_o, m_rop);
            end
         end
      end
   end

   // ---------------- Event monitor for directed expectations ----------------
   int         cyc = 0, en_rises = 0, err_cnt = 0, hs_cnt = 0, rv_cycles = 0;
   int         en_run = 0, en_rise_cyc = 0, err_cyc = 0;
   int         en_len_q[$], en_fall_q[$];
   logic [2:0] hs_op_q[$];
   logic [15:0] hs_data_q[$];
   bit         prev_en = 0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (core_en_o === 1'b1) begin
            if (!prev_en) begin
               en_rises++; en_rise_cyc = cyc; en_run = 0;
            end
            en_run++;
         end else if (prev_en) begin
            en_len_q.push_back(en_run); en_fall_q.push_back(cyc);
         end
         prev_en = (core_en_o === 1'b1);
         if (err_o === 1'b1) begin
            err_cnt++; err_cyc = cyc;
         end
         if (res_valid_o === 1'b1) rv_cycles++;
         if (res_valid_o === 1'b1 && res_ready_i === 1'b1) begin
            hs_cnt++; hs_op_q.push_back(res_op_o); hs_data_q.push_back(res_data_o);
         end
      end
   end

   // ---------------- Core stand-in ----------------
   int en_cyc = 0;
   bit hang_once = 0, hang_cur = 0, spurious = 0;

   initial begin
      core_valid_i = 0; core_result_i = 0;
      forever begin
         @(negedge clk);
         if (core_en_o === 1'b1) begin
            en_cyc++;
            if (en_cyc == 1) begin
               hang_cur = hang_once; hang_once = 0;
            end
            core_valid_i = !hang_cur && (en_cyc == ((core_op_o == 3'd3) ? 4 : 3));
            core_result_i = core_valid_i ? core_fn(core_op_o, core_a_o, core_b_o)
                                         : 16'($urandom);
         end else begin
            en_cyc = 0;
            core_valid_i = spurious && ($urandom_range(0, 7) == 0);
            core_result_i = 16'($urandom);
         end
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic push(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      in_valid_i = 1; in_op_i = op; in_a_i = a; in_b_i = b;
      @(negedge clk);
      while (!in_ready_o && n < 200) begin
         @(negedge clk); n++;
      end
      check("push_accept_bound", (n < 200), 1);
      @(posedge clk); #1;
      in_valid_i = 0;
   endtask

   task automatic try_push(input logic [2:0] op, output bit acc);
      in_valid_i = 1; in_op_i = op; in_a_i = 16'($urandom); in_b_i = 16'($urandom);
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk); #1;
      in_valid_i = 0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy_o !== 1'b0 && n < 500) begin
         step(1); n++;
      end
      check(name, (n < 500), 1);
   endtask

   task automatic wait_res(input string name);
      int n = 0;
      while (res_valid_o !== 1'b1 && n < 200) begin
         step(1); n++;
      end
      check(name, (n < 200), 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "global timeout");
   end

   // ---------------- Directed scenarios and random traffic ----------------
   initial begin
      logic [2:0]  t_op [5];
      logic [15:0] t_a [5], t_b [5];
      logic [15:0] ea, eb;
      int          base, lbase, e0, r0, rv0;
      bit          acc;

      rst = 0; in_valid_i = 0; in_op_i = 0; in_a_i = 0; in_b_i = 0; res_ready_i = 1;
      step(3);
      check("rst_in_ready", in_ready_o, 0);
      check("rst_core_en", core_en_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_res_valid", res_valid_o, 0);
      check("rst_err", err_o, 0);
      rst = 1; #1;
      check("release_in_ready", in_ready_o, 1);

      // Single ADD: 3 enabled cycles, one-cycle result pulse
      base = hs_cnt; rv0 = rv_cycles; lbase = en_len_q.size();
      push(3'd0, 16'h4000, 16'h4000);
      check("issue_not_same_cycle", core_en_o, 0);
      step(1);
      check("issue_next_cycle", core_en_o, 1);
      wait_idle("add_done");
      check("add_en_cycles", en_len_q[lbase], 3);
      check("add_results", hs_cnt - base, 1);
      check("add_data", hs_data_q[base], 16'h5000);
      check("add_op", hs_op_q[base], 0);
      check("add_rv_cycles", rv_cycles - rv0, 1);
      check("add_busy_clear", busy_o, 0);

      // Fill past the FIFO with the consumer stalled
      res_ready_i = 0; base = hs_cnt;
      t_op[0] = 0; t_op[1] = 1; t_op[2] = 2; t_op[3] = 3; t_op[4] = 0;
      for (int i = 0; i < 5; i++) begin
         t_a[i] = 16'($urandom); t_b[i] = 16'($urandom);
         push(t_op[i], t_a[i], t_b[i]);
      end
      check("full_ready_low", in_ready_o, 0);
      try_push(3'd1, acc);
      check("sixth_stalls", acc, 0);
      res_ready_i = 1;
      wait_idle("fill_drain");
      check("fill_results", hs_cnt - base, 5);
      for (int i = 0; i < 5; i++) begin
         check("fill_op_order", hs_op_q[base + i], t_op[i]);
         check("fill_data", hs_data_q[base + i], core_fn(t_op[i], t_a[i], t_b[i]));
      end

      // Rejected opcode followed by MUL
      base = hs_cnt; e0 = err_cnt; r0 = en_rises;
      ea = 16'($urandom); eb = 16'($urandom);
      push(3'd4, 16'h1234, 16'h5678);
      push(3'd2, ea, eb);
      wait_idle("reject_done");
      check("reject_err_once", err_cnt - e0, 1);
      check("reject_one_issue", en_rises - r0, 1);
      check("reject_mul_next_cycle", en_rise_cyc, err_cyc + 1);
      check("reject_mul_op", hs_op_q[base], 2);
      check("reject_mul_data", hs_data_q[base], core_fn(3'd2, ea, eb));

      // Hung DIV times out, the queued ADD still completes
      base = hs_cnt; e0 = err_cnt; r0 = en_rises; lbase = en_len_q.size();
      hang_once = 1;
      ea = 16'($urandom); eb = 16'($urandom);
      push(3'd3, 16'h7000, 16'h0100);
      push(3'd0, ea, eb);
      wait_idle("timeout_done");
      check("timeout_err_once", err_cnt - e0, 1);
      check("timeout_two_issues", en_rises - r0, 2);
      check("timeout_wait_cycles", en_len_q[lbase], 15);
      check("timeout_err_at_fall", err_cyc, en_fall_q[lbase]);
      check("timeout_next_latency", en_len_q[lbase + 1], 3);
      check("timeout_results", hs_cnt - base, 1);
      check("timeout_next_op", hs_op_q[base], 0);

      // Result held under backpressure; queued op must not issue
      res_ready_i = 0; base = hs_cnt; r0 = en_rises;
      ea = 16'($urandom); eb = 16'($urandom);
      push(3'd2, ea, eb);
      push(3'd1, 16'h0042, 16'h0800);
      wait_res("hold_res_seen");
      for (int i = 0; i < 10; i++) begin
         check("hold_valid", res_valid_o, 1);
         check("hold_data", res_data_o, core_fn(3'd2, ea, eb));
         check("hold_no_issue", core_en_o, 0);
         step(1);
      end
      check("hold_issues", en_rises - r0, 1);
      res_ready_i = 1; step(1); res_ready_i = 0;
      check("hold_single_handshake", hs_cnt - base, 1);
      wait_res("hold_second_res");
      res_ready_i = 1;
      wait_idle("hold_done");
      check("hold_second_op", hs_op_q[base + 1], 1);
      check("hold_second_data", hs_data_q[base + 1], core_fn(3'd1, 16'h0042, 16'h0800));

      // Reset while waiting with three ops queued
      e0 = err_cnt;
      push(3'd3, 16'h1111, 16'h2222);
      push(3'd0, 16'h0001, 16'h0002);
      push(3'd1, 16'h0003, 16'h0004);
      push(3'd2, 16'h0005, 16'h0006);
      check("pre_reset_waiting", core_en_o, 1);
      rst = 0;
      step(1);
      check("mid_rst_core_en", core_en_o, 0);
      check("mid_rst_core_op", core_op_o, 0);
      check("mid_rst_core_a", core_a_o, 0);
      check("mid_rst_core_b", core_b_o, 0);
      check("mid_rst_res_valid", res_valid_o, 0);
      check("mid_rst_res_data", res_data_o, 0);
      check("mid_rst_res_op", res_op_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_in_ready", in_ready_o, 0);
      rst = 1; #1;
      check("post_rst_in_ready", in_ready_o, 1);
      r0 = en_rises;
      step(6);
      check("post_rst_fifo_empty", busy_o, 0);
      check("post_rst_no_issue", en_rises - r0, 0);
      check("post_rst_no_err", err_cnt - e0, 0);

      // Randomized traffic with occasional resets, hangs and stray core_valid
      base = hs_cnt; spurious = 1;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 399) != 0);
         in_valid_i = ($urandom_range(0, 9) < 6);
         in_op_i = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                               : 3'($urandom_range(0, 3));
         in_a_i = 16'($urandom);
         in_b_i = 16'($urandom);
         res_ready_i = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 49) == 0) hang_once = 1;
         step(1);
      end
      rst = 1; in_valid_i = 0; res_ready_i = 1; spurious = 0;
      wait_idle("random_drain");
      check("random_results_seen", (hs_cnt - base) > 50, 1);
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
